// File: rtl/mem_sram_controller.sv
// mem_sram_controller: EXE-stage memory responder.
// It serves each 32-bit load or store as two 16-bit accesses on an external
// asynchronous SRAM, low half first. o_ready stays low while an access is in
// flight so the pipeline freezes.
// Optional build macro MEM_SRAM_ALIGN_CHECK_EN adds o_misalign_err. With it
// defined, requests whose address is not word-aligned complete without
// touching the SRAM.
module mem_sram_controller #(
  parameter int unsigned WAIT_CYCLES     = 2,     // cycles per 16-bit phase, 1..15
  parameter int unsigned BASE_ADDR       = 1024,  // CPU byte address of SRAM word 0
  parameter int unsigned SRAM_ADDR_WIDTH = 18
) (
  input  logic                       i_clk,
  input  logic                       i_rst,        // synchronous, active-low
  input  logic                       i_mem_read,
  input  logic                       i_mem_write,
  input  logic [31:0]                i_address,
  input  logic [31:0]                i_write_data,
  output logic [31:0]                o_read_data,
  output logic                       o_ready,
  output logic [SRAM_ADDR_WIDTH-1:0] o_sram_addr,
  input  logic [15:0]                i_sram_dq_in,
  output logic [15:0]                o_sram_dq_out,
  output logic                       o_sram_dq_oe,
`ifdef MEM_SRAM_ALIGN_CHECK_EN
  output logic                       o_misalign_err,
`endif
  output logic                       o_sram_we_n
);

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StWrLo,
    StWrHi,
    StDone
  } state_e;

  localparam logic [3:0] LastCnt = 4'(WAIT_CYCLES - 1);

  state_e                     r_state;
  logic [3:0]                 r_cnt;
  logic [SRAM_ADDR_WIDTH-2:0] r_word;
  logic [31:0]                r_wdata;
  logic [31:0]                r_rdata;
  logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr;
  logic [15:0]                r_dq_out;
  logic                       r_dq_oe;
  logic                       r_we_n;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
  logic                       r_misalign;
`endif

  logic [31:0]                w_offset;
  logic [SRAM_ADDR_WIDTH-2:0] w_word;
  logic                       w_last;
  logic                       w_unused_offset;

  // Byte offset into the SRAM window. Only the word-index bits select SRAM data.
  assign w_offset        = i_address - 32'(BASE_ADDR);
  assign w_word          = w_offset[SRAM_ADDR_WIDTH:2];
  assign w_unused_offset = ^{w_offset[31:SRAM_ADDR_WIDTH+1], w_offset[1:0]};
  assign w_last          = (r_cnt == LastCnt);

  // Ready is low from the acceptance cycle through the last SRAM phase.
  assign o_ready = (r_state == StDone) ||
                   ((r_state == StIdle) && !i_mem_read && !i_mem_write);

  assign o_read_data   = r_rdata;
  assign o_sram_addr   = r_sram_addr;
  assign o_sram_dq_out = r_dq_out;
  assign o_sram_dq_oe  = r_dq_oe;
  assign o_sram_we_n   = r_we_n;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
  assign o_misalign_err = r_misalign;
`endif

  // Access sequencer. SRAM strobes are set one edge ahead so that each phase
  // presents stable address, data and strobes from its first cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= 4'd0;
      r_word      <= '0;
      r_wdata     <= 32'd0;
      r_rdata     <= 32'd0;
      r_sram_addr <= '0;
      r_dq_out    <= 16'd0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
`ifdef MEM_SRAM_ALIGN_CHECK_EN
      r_misalign <= 1'b0;
`endif
      unique case (r_state)
        StIdle: begin
          if (i_mem_write || i_mem_read) begin
            r_word  <= w_word;
            r_wdata <= i_write_data;
            r_cnt   <= 4'd0;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
            if (i_address[1:0] != 2'b00) begin
              r_state    <= StDone;
              r_misalign <= 1'b1;
            end else
`endif
            if (i_mem_write) begin
              r_state     <= StWrLo;
              r_sram_addr <= {w_word, 1'b0};
              r_dq_out    <= i_write_data[15:0];
              r_dq_oe     <= 1'b1;
              r_we_n      <= 1'b0;
            end else begin
              r_state     <= StRdLo;
              r_sram_addr <= {w_word, 1'b0};
            end
          end
        end
        StRdLo: begin
          if (w_last) begin
            r_rdata[15:0] <= i_sram_dq_in;
            r_state       <= StRdHi;
            r_cnt         <= 4'd0;
            r_sram_addr   <= {r_word, 1'b1};
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StRdHi: begin
          if (w_last) begin
            r_rdata[31:16] <= i_sram_dq_in;
            r_state        <= StDone;
            r_cnt          <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StWrLo: begin
          if (w_last) begin
            r_state     <= StWrHi;
            r_cnt       <= 4'd0;
            r_sram_addr <= {r_word, 1'b1};
            r_dq_out    <= r_wdata[31:16];
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StWrHi: begin
          if (w_last) begin
            r_state <= StDone;
            r_cnt   <= 4'd0;
            r_we_n  <= 1'b1;
            r_dq_oe <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_cnt   <= 4'd0;
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 4'd0;
          r_we_n  <= 1'b1;
          r_dq_oe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_controller.sv
// Self-checking bench for mem_sram_controller.
// A behavioural SRAM answers the bus, and a word-level reference memory
// predicts load results, per-phase bus activity and ready-low duration.
module tb_mem_sram_controller;

  localparam int W    = 2;
  localparam int BASE = 1024;
  localparam int AW   = 18;

  logic          clk;
  logic          rst;
  logic          mem_read;
  logic          mem_write;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_in;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic          sram_we_n;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
  logic          misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ref_mem [0:127];
  logic [31:0] exp_rdata;

  logic [15:0] sram [0:255];
  logic        written [0:255];

  mem_sram_controller #(
    .WAIT_CYCLES    (W),
    .BASE_ADDR      (BASE),
    .SRAM_ADDR_WIDTH(AW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_mem_read    (mem_read),
    .i_mem_write   (mem_write),
    .i_address     (address),
    .i_write_data  (write_data),
    .o_read_data   (read_data),
    .o_ready       (ready),
    .o_sram_addr   (sram_addr),
    .i_sram_dq_in  (sram_dq_in),
    .o_sram_dq_out (sram_dq_out),
    .o_sram_dq_oe  (sram_dq_oe),
`ifdef MEM_SRAM_ALIGN_CHECK_EN
    .o_misalign_err(misalign_err),
`endif
    .o_sram_we_n   (sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up content of each SRAM halfword.
  function automatic logic [15:0] init_fn(input logic [7:0] h);
    return {h, ~h} ^ 16'hA5C3;
  endfunction

  // Asynchronous SRAM: writes while we_n is low, reads combinationally.
  always @(posedge clk) begin
    if (sram_we_n === 1'b0) begin
      sram[sram_addr[7:0]]    <= sram_dq_out;
      written[sram_addr[7:0]] <= 1'b1;
    end
  end

  assign sram_dq_in = (written[sram_addr[7:0]] === 1'b1) ? sram[sram_addr[7:0]]
                                                         : init_fn(sram_addr[7:0]);

  // One request from acceptance to its ready-high cycle, checked every cycle.
  task automatic run_access(input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata);
    int unsigned word;
    bit          mis;
    bit          done;
    int          lows;
    int          half;
    int          exp_lows;
    logic [AW-1:0] exp_addr;
    logic [15:0]   exp_dq;
    word = (addr - BASE) >> 2;
    mis  = 1'b0;
`ifdef MEM_SRAM_ALIGN_CHECK_EN
    mis = (addr[1:0] != 2'b00);
`endif
    @(posedge clk);
    #1;
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wdata;
    done = 1'b0;
    lows = 0;
    for (int g = 0; g < 64 && !done; g++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        done = 1'b1;
      end else begin
        if (lows == 0 || mis || !wr) begin
          n_checks++;
          if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_idle_or_read addr=%h cyc=%0d we_n=%b oe=%b required we_n=1 oe=0",
                     addr, lows, sram_we_n, sram_dq_oe);
          end
        end
        if (lows > 0 && !mis) begin
          half     = (lows - 1) / W;
          exp_addr = AW'(word * 2 + half);
          n_checks++;
          if (sram_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL sram_addr addr=%h cyc=%0d got=%0d required=%0d",
                     addr, lows, sram_addr, exp_addr);
          end
          if (wr) begin
            exp_dq = (half == 0) ? wdata[15:0] : wdata[31:16];
            n_checks++;
            if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_dq_out !== exp_dq) begin
              n_fail++;
              $display("FAIL write_phase addr=%h cyc=%0d we_n=%b oe=%b dq=%h required 0 1 %h",
                       addr, lows, sram_we_n, sram_dq_oe, sram_dq_out, exp_dq);
            end
          end
        end
        lows++;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL ready_timeout addr=%h got no ready within 64 cycles required ready=1", addr);
    end
    exp_lows = mis ? 1 : 1 + 2 * W;
    n_checks++;
    if (lows != exp_lows) begin
      n_fail++;
      $display("FAIL ready_low_cycles addr=%h got=%0d required=%0d", addr, lows, exp_lows);
    end
    if (!mis) begin
      if (wr) ref_mem[word] = wdata;
      else    exp_rdata     = ref_mem[word];
    end
    n_checks++;
    if (read_data !== exp_rdata || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle addr=%h rd=%b wr=%b read_data=%h we_n=%b oe=%b required %h 1 0",
               addr, rd, wr, read_data, sram_we_n, sram_dq_oe, exp_rdata);
    end
`ifdef MEM_SRAM_ALIGN_CHECK_EN
    n_checks++;
    if (misalign_err !== mis) begin
      n_fail++;
      $display("FAIL misalign_err addr=%h got=%b required=%b", addr, misalign_err, mis);
    end
`endif
  endtask

  // Drop requests and confirm the controller stays idle with read_data held.
  task automatic idle(input int n);
    @(posedge clk);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (n) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || read_data !== exp_rdata) begin
        n_fail++;
        $display("FAIL idle_hold ready=%b we_n=%b read_data=%h required 1 1 %h",
                 ready, sram_we_n, read_data, exp_rdata);
      end
    end
  endtask

  task automatic test_reset();
    rst        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = BASE;
    write_data = 32'hCAFEF00D;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'd0 ||
          sram_addr !== '0 || sram_dq_out !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_state we_n=%b oe=%b rdata=%h addr=%h dq=%h required 1 0 0 0 0",
                 sram_we_n, sram_dq_oe, read_data, sram_addr, sram_dq_out);
      end
    end
    rst       = 1'b1;
    mem_write = 1'b0;
    exp_rdata = 32'd0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release ready=%b we_n=%b required 1 1", ready, sram_we_n);
    end
  endtask

  task automatic test_write();
    run_access(1'b0, 1'b1, 32'(BASE), 32'hDEADBEEF);
    idle(1);
  endtask

  task automatic test_read();
    run_access(1'b1, 1'b0, 32'(BASE), 32'h0);
    idle(2);
  endtask

  task automatic test_back_to_back();
    run_access(1'b0, 1'b1, 32'(BASE + 8), 32'h0BAD_F00D);
    run_access(1'b1, 1'b0, 32'(BASE + 12), 32'h0);
    run_access(1'b1, 1'b0, 32'(BASE + 8), 32'h0);
    idle(3);
  endtask

  task automatic test_both_requests();
    run_access(1'b1, 1'b1, 32'(BASE), 32'h12345678);
    idle(1);
    run_access(1'b1, 1'b0, 32'(BASE), 32'h0);
    idle(1);
  endtask

  // Abort a write during its high phase. The data matches what the word holds already.
  task automatic test_reset_mid();
    @(posedge clk);
    #1;
    mem_write  = 1'b1;
    address    = BASE;
    write_data = 32'h12345678;
    repeat (W + 2) @(negedge clk);
    n_checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== AW'(1)) begin
      n_fail++;
      $display("FAIL mid_write_hi we_n=%b addr=%0d required 0 1", sram_we_n, sram_addr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || read_data !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset_abort we_n=%b oe=%b rdata=%h required 1 0 0",
               sram_we_n, sram_dq_oe, read_data);
    end
    rst       = 1'b1;
    mem_write = 1'b0;
    exp_rdata = 32'd0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
        n_fail++;
        $display("FAIL post_abort_idle ready=%b we_n=%b required 1 1", ready, sram_we_n);
      end
    end
  endtask

  // Misaligned load: either a one-cycle error completion or a containing-word load.
  task automatic test_misaligned();
    run_access(1'b1, 1'b0, 32'(BASE + 2), 32'h0);
    idle(1);
    run_access(1'b1, 1'b0, 32'(BASE + 15), 32'h0);
    idle(1);
  endtask

  task automatic test_random();
    int unsigned op;
    int unsigned word;
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 2);
      word = $urandom_range(0, 127);
      addr = 32'(BASE) + 32'(word * 4) + 32'($urandom_range(0, 3));
      run_access(op != 1, op != 0, addr, $urandom);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
  endtask

  initial begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    rst        = 1'b0;
    exp_rdata  = 32'd0;
    for (int w = 0; w < 128; w++) begin
      ref_mem[w] = {init_fn(8'(2 * w + 1)), init_fn(8'(2 * w))};
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_both_requests();
    test_reset_mid();
    test_misaligned();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
